// File: rtl/wash_sequencer.sv
// wash_sequencer: tick-paced phase timer for a washing-machine program.
//   A free-running prescaler produces one tick every TICK_DIV clocks; all
//   state-dependent register updates happen only on tick edges.
//   In run, the highest-numbered nonzero phase field counts down to zero,
//   then had_finish is raised and held.
// Ports:
//   clk         - clock, rising edge
//   rst         - synchronous active-high reset
//   state       - machine state (0 shutDown,1 begin,2 set,3 run,4 error,
//                 5 pause,6 finish,7 as shutDown)
//   load_data   - phase times, field i at [i*CNT_W +: CNT_W]
//   remaining   - registered remaining time per phase
//   phase_idx   - highest nonzero field of remaining (combinational)
//   had_finish  - registered program-complete flag
//   start_cnt   - registered begin countdown
//   finish_cnt  - registered finish countdown
//   phase_done  - per-phase completion pulse
// Optional feature: define WASH_SEQ_PHASE_DONE_EN to build phase_done pulses;
// otherwise phase_done is tied to zero.
module wash_sequencer #(
  parameter int unsigned PHASES     = 4,
  parameter int unsigned CNT_W      = 4,
  parameter int unsigned TICK_DIV   = 5,
  parameter int unsigned START_CNT  = 5,
  parameter int unsigned FINISH_CNT = 5,
  localparam int unsigned PHASE_W   = (PHASES > 1) ? $clog2(PHASES) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [2:0]                state,
  input  logic [PHASES*CNT_W-1:0]   load_data,
  output logic [PHASES*CNT_W-1:0]   remaining,
  output logic [PHASE_W-1:0]        phase_idx,
  output logic                      had_finish,
  output logic [3:0]                start_cnt,
  output logic [3:0]                finish_cnt,
  output logic [PHASES-1:0]         phase_done
);

  localparam int unsigned DATA_W = PHASES * CNT_W;
  localparam int unsigned PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [2:0] {
    ST_SHUTDOWN = 3'd0,
    ST_BEGIN    = 3'd1,
    ST_SET      = 3'd2,
    ST_RUN      = 3'd3,
    ST_ERROR    = 3'd4,
    ST_PAUSE    = 3'd5,
    ST_FINISH   = 3'd6,
    ST_SPARE    = 3'd7
  } state_e;

  state_e st_c;
  assign st_c = state_e'(state);

  logic [PRE_W-1:0]   presc_q, presc_d;
  logic [DATA_W-1:0]  remaining_q, remaining_d;
  logic               armed_q, armed_d;
  logic               had_finish_q, had_finish_d;
  logic [3:0]         start_cnt_q, start_cnt_d;
  logic [3:0]         finish_cnt_q, finish_cnt_d;

  logic               tick_c;
  logic               any_nz_c;
  logic [PHASE_W-1:0] phase_idx_c;
  logic [DATA_W-1:0]  dec_c;

  // Prescaler: tick on the terminal count, then wrap.
  always_comb begin
    tick_c  = (presc_q == PRE_W'(TICK_DIV - 1));
    presc_d = tick_c ? '0 : presc_q + PRE_W'(1);
  end

  // Highest-numbered nonzero field; later iterations override earlier ones.
  always_comb begin
    phase_idx_c = '0;
    for (int i = 0; i < PHASES; i++) begin
      if (remaining_q[i*CNT_W +: CNT_W] != '0) phase_idx_c = PHASE_W'(i);
    end
  end

  assign any_nz_c = |remaining_q;

  // Remaining vector with only the active field decremented.
  always_comb begin
    dec_c = remaining_q;
    for (int i = 0; i < PHASES; i++) begin
      if (any_nz_c && (phase_idx_c == PHASE_W'(i))) begin
        dec_c[i*CNT_W +: CNT_W] = remaining_q[i*CNT_W +: CNT_W] - CNT_W'(1);
      end
    end
  end

  // Per-state register update, applied only on tick edges.
  always_comb begin
    remaining_d  = remaining_q;
    armed_d      = armed_q;
    had_finish_d = had_finish_q;
    start_cnt_d  = start_cnt_q;
    finish_cnt_d = finish_cnt_q;
    if (tick_c) begin
      case (st_c)
        ST_SET: begin
          armed_d      = 1'b1;
          remaining_d  = load_data;
          had_finish_d = 1'b0;
          start_cnt_d  = 4'(START_CNT);
          finish_cnt_d = 4'(FINISH_CNT);
        end
        ST_RUN: begin
          start_cnt_d  = 4'(START_CNT);
          finish_cnt_d = 4'(FINISH_CNT);
          if (armed_q) begin
            remaining_d = load_data;
            armed_d     = 1'b0;
          end else if (any_nz_c) begin
            remaining_d = dec_c;
          end else begin
            had_finish_d = 1'b1;
          end
        end
        ST_BEGIN: begin
          start_cnt_d  = (start_cnt_q == 4'd0) ? 4'd0 : start_cnt_q - 4'd1;
          remaining_d  = load_data;
          had_finish_d = 1'b0;
          finish_cnt_d = 4'(FINISH_CNT);
          armed_d      = 1'b0;
        end
        ST_FINISH: begin
          finish_cnt_d = (finish_cnt_q == 4'd0) ? 4'd0 : finish_cnt_q - 4'd1;
          remaining_d  = load_data;
          had_finish_d = 1'b0;
          start_cnt_d  = 4'(START_CNT);
        end
        ST_PAUSE: begin
          had_finish_d = 1'b0;
          start_cnt_d  = 4'(START_CNT);
          finish_cnt_d = 4'(FINISH_CNT);
        end
        default: begin
          remaining_d  = load_data;
          had_finish_d = 1'b0;
          start_cnt_d  = 4'(START_CNT);
          finish_cnt_d = 4'(FINISH_CNT);
          armed_d      = 1'b0;
        end
      endcase
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q      <= '0;
      remaining_q  <= '0;
      armed_q      <= 1'b0;
      had_finish_q <= 1'b0;
      start_cnt_q  <= 4'(START_CNT);
      finish_cnt_q <= 4'(FINISH_CNT);
    end else begin
      presc_q      <= presc_d;
      remaining_q  <= remaining_d;
      armed_q      <= armed_d;
      had_finish_q <= had_finish_d;
      start_cnt_q  <= start_cnt_d;
      finish_cnt_q <= finish_cnt_d;
    end
  end

`ifdef WASH_SEQ_PHASE_DONE_EN
  logic [PHASES-1:0] phase_done_q, phase_done_d;

  // One-clock pulse for the field that steps 1->0 on a run tick.
  always_comb begin
    phase_done_d = '0;
    if (tick_c && (st_c == ST_RUN) && !armed_q) begin
      for (int i = 0; i < PHASES; i++) begin
        if (any_nz_c && (phase_idx_c == PHASE_W'(i)) &&
            (remaining_q[i*CNT_W +: CNT_W] == CNT_W'(1))) begin
          phase_done_d[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) phase_done_q <= '0;
    else     phase_done_q <= phase_done_d;
  end

  assign phase_done = phase_done_q;
`else
  assign phase_done = '0;
`endif

  assign remaining  = remaining_q;
  assign phase_idx  = phase_idx_c;
  assign had_finish = had_finish_q;
  assign start_cnt  = start_cnt_q;
  assign finish_cnt = finish_cnt_q;

endmodule

// File: tb/tb_wash_sequencer.sv
// Bench for wash_sequencer with PHASES=4, CNT_W=4, TICK_DIV=2.
// Stimulus pushes hand-computed expectations into a queue; a monitor on the
// falling edge pops and compares them against the outputs.
module tb_wash_sequencer;

  logic        clk;
  logic        rst;
  logic [2:0]  state;
  logic [15:0] load_data;
  logic [15:0] remaining;
  logic [1:0]  phase_idx;
  logic        had_finish;
  logic [3:0]  start_cnt;
  logic [3:0]  finish_cnt;
  logic [3:0]  phase_done;

  wash_sequencer #(
    .PHASES(4), .CNT_W(4), .TICK_DIV(2), .START_CNT(5), .FINISH_CNT(5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .state      (state),
    .load_data  (load_data),
    .remaining  (remaining),
    .phase_idx  (phase_idx),
    .had_finish (had_finish),
    .start_cnt  (start_cnt),
    .finish_cnt (finish_cnt),
    .phase_done (phase_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] rem;
    logic        hf;
    logic [3:0]  sc;
    logic [3:0]  fc;
    logic [3:0]  pd;
    logic [1:0]  idx;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Queue an expectation; pd_on applies only when phase_done is built.
  task automatic expect_out(input string nm, input logic [15:0] rem,
                            input logic hf, input logic [3:0] sc,
                            input logic [3:0] fc, input logic [3:0] pd_on,
                            input logic [1:0] idx);
    exp_t e;
    e.name = nm; e.rem = rem; e.hf = hf; e.sc = sc; e.fc = fc; e.idx = idx;
`ifdef WASH_SEQ_PHASE_DONE_EN
    e.pd = pd_on;
`else
    e.pd = 4'h0;
`endif
    exp_q.push_back(e);
  endtask

  // Monitor: compare every pending expectation mid-cycle.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      total++;
      if (remaining !== e.rem || had_finish !== e.hf || start_cnt !== e.sc ||
          finish_cnt !== e.fc || phase_done !== e.pd || phase_idx !== e.idx) begin
        bad++;
        $display("FAIL %s: got rem=%h hf=%b sc=%0d fc=%0d pd=%b idx=%0d, want rem=%h hf=%b sc=%0d fc=%0d pd=%b idx=%0d",
                 e.name, remaining, had_finish, start_cnt, finish_cnt, phase_done,
                 phase_idx, e.rem, e.hf, e.sc, e.fc, e.pd, e.idx);
      end
    end
  end

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  // Advance to just after the next tick edge (bench stays tick-aligned).
  task automatic do_tick();
    edge1();
    edge1();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  logic [3:0]  begin_tbl [7];
  logic [15:0] run_rem   [7];
  logic [1:0]  run_idx   [7];
  logic [3:0]  run_pd    [7];
  logic [3:0]  fin_tbl   [3];

  initial begin
    begin_tbl = '{4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd0, 4'd0};
    run_rem   = '{16'h1203, 16'h0203, 16'h0103, 16'h0003, 16'h0002, 16'h0001, 16'h0000};
    run_idx   = '{2'd3, 2'd2, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0};
    run_pd    = '{4'h0, 4'h8, 4'h0, 4'h4, 4'h0, 4'h0, 4'h1};
    fin_tbl   = '{4'd4, 4'd3, 4'd2};

    rst = 1'b1; state = 3'd0; load_data = 16'h1111;
    edge1(); edge1();
    expect_out("reset", 16'h0000, 1'b0, 4'd5, 4'd5, 4'h0, 2'd0);
    rst = 1'b0;

    // Tick timing: updates land only every second clock.
    edge1(); expect_out("pre_tick", 16'h0000, 1'b0, 4'd5, 4'd5, 4'h0, 2'd0);
    edge1(); expect_out("tick1",    16'h1111, 1'b0, 4'd5, 4'd5, 4'h0, 2'd3);
    load_data = 16'h2222;
    edge1(); expect_out("between",  16'h1111, 1'b0, 4'd5, 4'd5, 4'h0, 2'd3);
    edge1(); expect_out("tick2",    16'h2222, 1'b0, 4'd5, 4'd5, 4'h0, 2'd3);

    // Begin countdown saturates at zero.
    state = 3'd1;
    for (int k = 0; k < 7; k++) begin
      do_tick();
      expect_out($sformatf("begin%0d", k), 16'h2222, 1'b0, begin_tbl[k], 4'd5, 4'h0, 2'd3);
    end

    // Set then run through the whole program.
    state = 3'd2; load_data = 16'h1203;
    do_tick(); expect_out("set", 16'h1203, 1'b0, 4'd5, 4'd5, 4'h0, 2'd3);
    state = 3'd3;
    for (int k = 0; k < 7; k++) begin
      do_tick();
      expect_out($sformatf("run%0d", k), run_rem[k], 1'b0, 4'd5, 4'd5, run_pd[k], run_idx[k]);
    end
    do_tick(); expect_out("run_fin",    16'h0000, 1'b1, 4'd5, 4'd5, 4'h0, 2'd0);
    do_tick(); expect_out("run_sticky", 16'h0000, 1'b1, 4'd5, 4'd5, 4'h0, 2'd0);

    // Finish countdown; clears had_finish and reloads remaining.
    state = 3'd6; load_data = 16'h0404;
    for (int k = 0; k < 3; k++) begin
      do_tick();
      expect_out($sformatf("finish%0d", k), 16'h0404, 1'b0, 4'd5, fin_tbl[k], 4'h0, 2'd2);
    end

    // Begin straight into run: not armed, so run decrements and reloads counts.
    state = 3'd1;
    do_tick(); expect_out("begin_b", 16'h0404, 1'b0, 4'd4, 4'd5, 4'h0, 2'd2);
    state = 3'd3;
    do_tick(); expect_out("run_noarm", 16'h0304, 1'b0, 4'd5, 4'd5, 4'h0, 2'd2);

    // Pause holds remaining regardless of load_data.
    state = 3'd2; load_data = 16'h0102;
    do_tick(); expect_out("set_p", 16'h0102, 1'b0, 4'd5, 4'd5, 4'h0, 2'd2);
    state = 3'd3;
    do_tick(); expect_out("run_p", 16'h0102, 1'b0, 4'd5, 4'd5, 4'h0, 2'd2);
    state = 3'd5; load_data = 16'hFFFF;
    for (int k = 0; k < 3; k++) begin
      do_tick();
      expect_out($sformatf("pause%0d", k), 16'h0102, 1'b0, 4'd5, 4'd5, 4'h0, 2'd2);
    end
    state = 3'd3;
    do_tick(); expect_out("resume", 16'h0002, 1'b0, 4'd5, 4'd5, 4'h4, 2'd0);

    // Phase done pulse lasts one clock.
    state = 3'd2; load_data = 16'h0010;
    do_tick(); expect_out("set_pd", 16'h0010, 1'b0, 4'd5, 4'd5, 4'h0, 2'd1);
    state = 3'd3;
    do_tick(); expect_out("run_pd0", 16'h0010, 1'b0, 4'd5, 4'd5, 4'h0, 2'd1);
    do_tick(); expect_out("run_pd1", 16'h0000, 1'b0, 4'd5, 4'd5, 4'h2, 2'd0);
    edge1();   expect_out("pd_clear", 16'h0000, 1'b0, 4'd5, 4'd5, 4'h0, 2'd0);
    edge1();   expect_out("hf_after", 16'h0000, 1'b1, 4'd5, 4'd5, 4'h0, 2'd0);

    // Reset mid-run, then first tick TICK_DIV clocks after release.
    state = 3'd2; load_data = 16'h0023;
    do_tick();
    state = 3'd3;
    do_tick(); expect_out("run_r", 16'h0023, 1'b0, 4'd5, 4'd5, 4'h0, 2'd1);
    rst = 1'b1;
    edge1(); expect_out("rst_mid", 16'h0000, 1'b0, 4'd5, 4'd5, 4'h0, 2'd0);
    rst = 1'b0; state = 3'd0; load_data = 16'h0007;
    edge1(); expect_out("rel_wait", 16'h0000, 1'b0, 4'd5, 4'd5, 4'h0, 2'd0);
    edge1(); expect_out("rel_tick", 16'h0007, 1'b0, 4'd5, 4'd5, 4'h0, 2'd0);

    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wash_sequencer.md
WASH_SEQUENCER -- requirements
Module: wash_sequencer

Interface
REQ-001 The block SHALL have parameter PHASES, default 4, giving the number of program phases (1..8).
REQ-002 The block SHALL have parameter CNT_W, default 4, giving the bit width of each phase's remaining-time field.
REQ-003 The block SHALL have parameter TICK_DIV, default 5, giving clk cycles per tick (>=1).
REQ-004 The block SHALL have parameter START_CNT, default 5, giving the begin-countdown reload value (0..15).
REQ-005 The block SHALL have parameter FINISH_CNT, default 5, giving the finish-countdown reload value (0..15).
REQ-006 PHASE_W SHALL equal max(1, clog2(PHASES)).
REQ-007 The block SHALL have port clk, input, width 1: the only clock; all flops clock on its rising edge.
REQ-008 The block SHALL have port rst, input, width 1: reset, synchronous and active-high.
REQ-009 The block SHALL have port state, input, width 3: machine state, encoded 0 shutDown, 1 begin, 2 set, 3 run, 4 error, 5 pause, 6 finish; 7 behaves as shutDown.
REQ-010 The block SHALL have port load_data, input, width PHASES*CNT_W: phase times, with field i at bits [i*CNT_W +: CNT_W].
REQ-011 The block SHALL have port remaining, output, width PHASES*CNT_W: registered remaining time per phase.
REQ-012 The block SHALL have port phase_idx, output, width PHASE_W: index of the highest-numbered nonzero field of remaining, combinational from remaining; 0 when all fields are zero.
REQ-013 The block SHALL have port had_finish, output, width 1: registered; program complete.
REQ-014 The block SHALL have port start_cnt, output, width 4: registered begin countdown.
REQ-015 The block SHALL have port finish_cnt, output, width 4: registered finish countdown.
REQ-016 The block SHALL have port phase_done, output, width PHASES: per-phase completion pulse (see Configuration).

Function
REQ-017 A free-running prescaler SHALL assert an internal tick for one clk when it reaches TICK_DIV-1, then wrap to 0; it SHALL run in every state.
REQ-018 All state-dependent register updates SHALL occur only on clk edges where tick=1; between ticks, every register SHALL hold its value.
REQ-019 In set, on tick: armed<=1, remaining<=load_data, had_finish<=0, start_cnt<=START_CNT, finish_cnt<=FINISH_CNT.
REQ-020 In run with armed=1, on tick: remaining<=load_data, armed<=0.
REQ-021 In run with armed=0, on tick: decrement by 1 only the highest-numbered nonzero field; no other field changes.
REQ-022 In run, on a tick where all fields are zero: had_finish<=1, held sticky while the state remains run.
REQ-023 In run, every tick SHALL also reload start_cnt and finish_cnt.
REQ-024 In begin, on tick: start_cnt decrements, saturating at 0; remaining<=load_data; had_finish<=0; finish_cnt<=FINISH_CNT; armed<=0.
REQ-025 In finish, on tick: finish_cnt decrements, saturating at 0; remaining<=load_data; had_finish<=0; start_cnt<=START_CNT.
REQ-026 In pause, on tick: remaining and armed hold; had_finish<=0; both countdowns reload.
REQ-027 In shutDown, error or 7, on tick: remaining<=load_data; had_finish<=0; countdowns reload; armed<=0.
REQ-028 No field SHALL ever wrap below 0; a decrement from 1 to 0 moves phase_idx down on the same edge.

Reset
REQ-029 When rst=1 at a clk edge, the following SHALL reset, overriding tick and state: prescaler=0, remaining=0, had_finish=0, armed=0, start_cnt=START_CNT, finish_cnt=FINISH_CNT, phase_done=0.
REQ-030 Reset asserted mid-run SHALL take effect at the next clk edge; the first tick after reset release SHALL occur TICK_DIV clks later.

Configuration
REQ-031 With macro WASH_SEQ_PHASE_DONE_EN defined, phase_done[i] SHALL pulse high for exactly one clk on the tick edge where field i decrements 1->0 in run.
REQ-032 With WASH_SEQ_PHASE_DONE_EN undefined, phase_done SHALL be constant 0 and no logic for it shall be built.

Verification (PHASES=4, CNT_W=4, TICK_DIV=2)
REQ-033 Tick timing: state=shutDown, load_data=16'h1111 -> remaining updates only every 2nd clk after reset release.
REQ-034 Set then run: load_data=16'h1203, set for 1 tick, then run -> 16'h1203, 16'h0203, 16'h0103, 16'h0003, 16'h0002, 16'h0001, 16'h0000, then had_finish=1 on the next tick.
REQ-035 Pause: remaining=16'h0102 in run, then pause 3 ticks -> remaining unchanged and had_finish=0; back to run -> 16'h0002 with phase_idx=0.
REQ-036 Begin saturation: begin held 7 ticks with START_CNT=5 -> start_cnt 4,3,2,1,0,0,0.
REQ-037 Reset mid-run: rst=1 while remaining=16'h0023 -> next clk remaining=0, had_finish=0, start_cnt=5, finish_cnt=5.
REQ-038 Phase done: remaining=16'h0010 in run, one tick -> remaining=0 and phase_done=4'b0010 for one clk with the macro defined; phase_done stays 0 without it.
